// File: rtl/apb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_pkg
// Description : Shared types and helpers for the APB slave register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        DEC_OK    = 2'd0,
        DEC_RANGE = 2'd1,
        DEC_ALIGN = 2'd2,
        DEC_RO    = 2'd3
    } dec_result_e;

    localparam int WCNT_WIDTH = 4;

    function automatic int byte_off_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_protocol_mon.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_protocol_mon
// Description : Sticky APB protocol-violation flag for one slave select.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_protocol_mon
    import apb_slave_pkg::*;
#(
    parameter int PADDR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   pclock,
    input  logic                   preset,
    input  logic                   psel,
    input  logic                   penable,
    input  logic [PADDR_WIDTH-1:0] paddr,
    input  logic                   prwd,
    input  logic [DATA_WIDTH-1:0]  pwdata,
    input  apb_state_e             state,
    input  logic                   prot_clr,
    output logic                   prot_err
);

    logic                   psel_prev_q,  psel_prev_d;
    logic [PADDR_WIDTH-1:0] addr_prev_q,  addr_prev_d;
    logic                   wr_prev_q,    wr_prev_d;
    logic [DATA_WIDTH-1:0]  wdata_prev_q, wdata_prev_d;
    logic                   prot_err_q,   prot_err_d;
    logic                   violation;

    always_comb begin
        psel_prev_d  = psel;
        addr_prev_d  = paddr;
        wr_prev_d    = prwd;
        wdata_prev_d = pwdata;

        violation = 1'b0;
        if (penable && !psel) begin
            violation = 1'b1;
        end
        if (penable && psel && !psel_prev_q) begin
            violation = 1'b1;
        end
        // ACCESS only lasts until the completing edge, so any change or a
        // dropped select seen here is before completion.
        if (state == ACCESS) begin
            if (!psel || (paddr != addr_prev_q) || (prwd != wr_prev_q) ||
                (pwdata != wdata_prev_q)) begin
                violation = 1'b1;
            end
        end

        prot_err_d = prot_err_q;
        if (violation) begin
            prot_err_d = 1'b1;
        end else if (prot_clr) begin
            prot_err_d = 1'b0;
        end
    end

    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            psel_prev_q  <= 1'b0;
            addr_prev_q  <= '0;
            wr_prev_q    <= 1'b0;
            wdata_prev_q <= '0;
            prot_err_q   <= 1'b0;
        end else begin
            psel_prev_q  <= psel_prev_d;
            addr_prev_q  <= addr_prev_d;
            wr_prev_q    <= wr_prev_d;
            wdata_prev_q <= wdata_prev_d;
            prot_err_q   <= prot_err_d;
        end
    end

    assign prot_err = prot_err_q;

endmodule
`default_nettype wire

// File: rtl/apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regbank
// Description : APB slave with a parametrised register bank, wait states,
//               per-register write protection and a sticky protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int                     PADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     NUM_REGS    = 16,
    parameter logic [PADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                     WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic                           pclock,
    input  logic                           preset,
    input  logic [PADDR_WIDTH-1:0]         paddr,
    input  logic                           prwd,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic                           psel,
    input  logic                           penable,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic                           prot_clr,
    output logic                           prot_err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int                     BOW        = byte_off_width(DATA_WIDTH);
    localparam int                     IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK = PADDR_WIDTH'((64'd1 << BOW) - 64'd1);
    localparam logic [WCNT_WIDTH-1:0]  WAIT_INIT  = WCNT_WIDTH'(WAIT_STATES);

    apb_state_e             state_q, state_d, state_cur;
    logic [WCNT_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [PADDR_WIDTH-1:0] addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];

    logic [PADDR_WIDTH-1:0] dec_addr, dec_off, dec_idx_full;
    logic                   dec_wr;
    logic [IDX_W-1:0]       dec_idx;
    dec_result_e            dec_res;
    logic                   done;

    // Outputs are registered, so the setup phase has to be acted on in the
    // cycle it is presented; otherwise a zero-wait transfer could not finish
    // in its first access cycle.
    always_comb begin
        state_cur = state_q;
        if ((state_q == IDLE) && psel && !penable) begin
            state_cur = SETUP;
        end
    end

    always_comb begin
        dec_addr     = (state_cur == SETUP) ? paddr : addr_q;
        dec_wr       = (state_cur == SETUP) ? prwd  : wr_q;
        dec_off      = dec_addr - BASE_ADDR;
        dec_idx_full = dec_off >> BOW;
        dec_idx      = dec_idx_full[IDX_W-1:0];
        if (dec_addr < BASE_ADDR) begin
            dec_res = DEC_RANGE;
        end else if ((dec_off & ALIGN_MASK) != '0) begin
            dec_res = DEC_ALIGN;
        end else if (dec_idx_full >= PADDR_WIDTH'(NUM_REGS)) begin
            dec_res = DEC_RANGE;
        end else if (dec_wr && RO_MASK[dec_idx]) begin
            dec_res = DEC_RO;
        end else begin
            dec_res = DEC_OK;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        regs_d    = regs_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        done      = 1'b0;

        case (state_cur)
            SETUP: begin
                state_d = ACCESS;
                addr_d  = paddr;
                wr_d    = prwd;
                wdata_d = pwdata;
                wcnt_d  = WAIT_INIT;
                done    = (WAIT_INIT == '0);
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (pready_q) begin
                    state_d = IDLE;
                    if (wr_q && (dec_res == DEC_OK)) begin
                        regs_d[dec_idx] = wdata_q;
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                    done   = (wcnt_q == WCNT_WIDTH'(1));
                end
            end
            default: ;
        endcase

        if (done) begin
            pready_d  = 1'b1;
            pslverr_d = (dec_res != DEC_OK);
            prdata_d  = (!dec_wr && (dec_res == DEC_OK)) ? regs_q[dec_idx] : '0;
        end
    end

    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            regs_q    <= '{default: RESET_VAL};
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            regs_q    <= regs_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
            assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    endgenerate

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

    apb_slave_protocol_mon #(
        .PADDR_WIDTH (PADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_mon (
        .pclock   (pclock),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .paddr    (paddr),
        .prwd     (prwd),
        .pwdata   (pwdata),
        .state    (state_cur),
        .prot_clr (prot_clr),
        .prot_err (prot_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regbank
// Description : Directed bench for two bank configurations (0 and 3 waits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regbank;

    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'h0000_2000;
    localparam logic [31:0] RV_A   = 32'h5A5A_0000;
    localparam logic [31:0] RV_B   = 32'h1234_5678;

    logic         clk = 1'b0;
    logic         preset = 1'b0;
    logic [31:0]  paddr = '0;
    logic         prwd = 1'b0;
    logic [31:0]  pwdata = '0;
    logic         prot_clr = 1'b0;
    logic         psel_a = 1'b0, penable_a = 1'b0, psel_b = 1'b0, penable_b = 1'b0;
    logic [31:0]  prdata_a, prdata_b;
    logic         pready_a, pready_b, pslverr_a, pslverr_b, prot_err_a, prot_err_b;
    logic [511:0] reg_q_a, reg_q_b;
    logic [511:0] exp_a, exp_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_slave_regbank #(
        .BASE_ADDR (BASE_A), .WAIT_STATES (0), .RO_MASK (16'h0000), .RESET_VAL (RV_A)
    ) dut_a (
        .pclock (clk), .preset (preset), .paddr (paddr), .prwd (prwd), .pwdata (pwdata),
        .psel (psel_a), .penable (penable_a), .prdata (prdata_a), .pready (pready_a),
        .pslverr (pslverr_a), .prot_clr (prot_clr), .prot_err (prot_err_a), .reg_q (reg_q_a)
    );

    apb_slave_regbank #(
        .BASE_ADDR (BASE_B), .WAIT_STATES (3), .RO_MASK (16'h0002), .RESET_VAL (RV_B)
    ) dut_b (
        .pclock (clk), .preset (preset), .paddr (paddr), .prwd (prwd), .pwdata (pwdata),
        .psel (psel_b), .penable (penable_b), .prdata (prdata_b), .pready (pready_b),
        .pslverr (pslverr_b), .prot_clr (prot_clr), .prot_err (prot_err_b), .reg_q (reg_q_b)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_set(input bit to_b, input bit sel, input bit en);
        psel_a = 1'b0; penable_a = 1'b0; psel_b = 1'b0; penable_b = 1'b0;
        if (to_b) begin
            psel_b = sel; penable_b = en;
        end else begin
            psel_a = sel; penable_a = en;
        end
    endtask

    // Setup + access; returns at the negedge where pready is seen high,
    // leaving the bus held so the following posedge completes the transfer.
    task automatic xfer(input bit to_b, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int cycles);
        logic rdy;
        @(negedge clk);
        paddr = addr; prwd = wr; pwdata = wdata;
        bus_set(to_b, 1'b1, 1'b0);
        @(negedge clk);
        bus_set(to_b, 1'b1, 1'b1);
        cycles = 1;
        rdy = to_b ? pready_b : pready_a;
        while (!rdy && cycles < 20) begin
            @(negedge clk);
            cycles++;
            rdy = to_b ? pready_b : pready_a;
        end
        rdata = to_b ? prdata_b : prdata_a;
        err   = to_b ? pslverr_b : pslverr_a;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus_set(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;

        for (int i = 0; i < 16; i++) begin
            exp_a[i*32 +: 32] = RV_A;
            exp_b[i*32 +: 32] = RV_B;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pready_a",  pready_a,   1'b0);
        check("rst_pslverr_a", pslverr_a,  1'b0);
        check("rst_prdata_a",  prdata_a,   32'h0);
        check("rst_prot_a",    prot_err_a, 1'b0);
        check("rst_regs_a",    reg_q_a,    exp_a);
        check("rst_regs_b",    reg_q_b,    exp_b);
        preset = 1'b1;

        // Zero-wait write then read of register 1
        xfer(1'b0, 1'b1, BASE_A + 32'h4, 32'hA5A5_0001, rd, er, cyc);
        check("wr_cycles_a", cyc, 1);
        check("wr_err_a",    er,  1'b0);
        go_idle();
        exp_a[63:32] = 32'hA5A5_0001;
        check("wr_regs_a", reg_q_a, exp_a);
        xfer(1'b0, 1'b0, BASE_A + 32'h4, 32'h0, rd, er, cyc);
        check("rd_cycles_a", cyc, 1);
        check("rd_data_a",   rd,  32'hA5A5_0001);
        check("rd_err_a",    er,  1'b0);
        go_idle();

        // Three wait states on a read of register 0
        xfer(1'b1, 1'b0, BASE_B, 32'h0, rd, er, cyc);
        check("ws_cycles_b", cyc, 4);
        check("ws_data_b",   rd,  RV_B);
        check("ws_err_b",    er,  1'b0);
        go_idle();

        // Out-of-range write and misaligned read
        xfer(1'b0, 1'b1, BASE_A + 32'h40, 32'hDEAD_BEEF, rd, er, cyc);
        check("range_err_a", er, 1'b1);
        go_idle();
        check("range_regs_a", reg_q_a, exp_a);
        xfer(1'b0, 1'b0, BASE_A + 32'h2, 32'h0, rd, er, cyc);
        check("align_err_a",  er, 1'b1);
        check("align_data_a", rd, 32'h0);
        go_idle();
        check("below_base_prot_a", prot_err_a, 1'b0);
        xfer(1'b0, 1'b0, BASE_A - 32'h4, 32'h0, rd, er, cyc);
        check("below_err_a", er, 1'b1);
        go_idle();

        // Read-only register 1 on B, writable register 2
        xfer(1'b1, 1'b1, BASE_B + 32'h4, 32'hFFFF_FFFF, rd, er, cyc);
        check("ro_err_b", er, 1'b1);
        go_idle();
        check("ro_regs_b", reg_q_b, exp_b);
        xfer(1'b1, 1'b1, BASE_B + 32'h8, 32'h0BAD_F00D, rd, er, cyc);
        check("rw_err_b", er, 1'b0);
        go_idle();
        exp_b[95:64] = 32'h0BAD_F00D;
        check("rw_regs_b", reg_q_b, exp_b);
        check("no_prot_b", prot_err_b, 1'b0);

        // Abort during a wait state
        @(negedge clk);
        paddr = BASE_B + 32'hC; prwd = 1'b1; pwdata = 32'h1111_2222;
        bus_set(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus_set(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        bus_set(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("abort_prot_b",  prot_err_b, 1'b1);
        check("abort_ready_b", pready_b,   1'b0);
        prot_clr = 1'b1;
        @(negedge clk);
        prot_clr = 1'b0;
        check("clr_prot_b", prot_err_b, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_regs_b", reg_q_b, exp_b);

        // Enable without a setup phase
        bus_set(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("nosetup_prot_b",  prot_err_b, 1'b1);
        check("nosetup_ready_b", pready_b,   1'b0);
        bus_set(1'b1, 1'b0, 1'b0);
        prot_clr = 1'b1;
        @(negedge clk);
        prot_clr = 1'b0;

        // Back-to-back writes with reset during the third access
        xfer(1'b0, 1'b1, BASE_A + 32'h10, 32'h0000_0D01, rd, er, cyc);
        check("b2b1_cycles_a", cyc, 1);
        xfer(1'b0, 1'b1, BASE_A + 32'h14, 32'h0000_0D02, rd, er, cyc);
        check("b2b2_cycles_a", cyc, 1);
        @(negedge clk);
        exp_a[159:128] = 32'h0000_0D01;
        exp_a[191:160] = 32'h0000_0D02;
        check("b2b_regs_a", reg_q_a, exp_a);
        paddr = BASE_A + 32'h18; prwd = 1'b1; pwdata = 32'h0000_0D03;
        bus_set(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus_set(1'b0, 1'b1, 1'b1);
        check("b2b3_ready_a", pready_a, 1'b1);
        preset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_a[i*32 +: 32] = RV_A;
        check("mid_rst_ready_a",   pready_a,   1'b0);
        check("mid_rst_pslverr_a", pslverr_a,  1'b0);
        check("mid_rst_prdata_a",  prdata_a,   32'h0);
        check("mid_rst_regs_a",    reg_q_a,    exp_a);
        @(negedge clk);
        preset = 1'b1;
        bus_set(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b1, BASE_A + 32'h1C, 32'h0000_0D04, rd, er, cyc);
        check("post_rst_cycles_a", cyc, 1);
        check("post_rst_err_a",    er,  1'b0);
        go_idle();
        exp_a[255:224] = 32'h0000_0D04;
        check("post_rst_regs_a", reg_q_a,    exp_a);
        check("post_rst_prot_a", prot_err_a, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
